mandelbrot_pixel_engine: RTL

Upstream compute stage feeding the multi-engine pixel combinator. Each instance computes Mandelbrot escape-time colours for a strided subset of the raster: pixel indices ENGINE_ID, ENGINE_ID+NUM_ENGINES, and so on, in raster order.
It holds each finished pixel (colour plus coordinates) until the combinator asserts taken, then advances to its next pixel. NUM_ENGINES instances run in parallel, one per combinator input slot.

---
 rtl/mandelbrot_pkg.sv | 31 +++
 rtl/mandelbrot_pixel_engine_pixel_stride_counter.sv | 39 +++
 rtl/mandelbrot_pixel_engine.sv | 137 +++++++++++++
 3 files changed

// File: rtl/mandelbrot_pkg.sv
// Shared fixed-point types, FSM encoding and helpers for the Mandelbrot pixel engine.
package mandelbrot_pkg;

  localparam int FX_WIDTH  = 32;
  localparam int FRAC_BITS = 24;

  typedef logic signed [FX_WIDTH-1:0] fx_t;

  localparam fx_t ESCAPE_R2 = 32'h04000000;

  typedef enum logic [1:0] {INIT, ITER, DONE} state_t;

  function automatic logic [23:0] colour_map(input logic [7:0] iter, input logic [7:0] max_iter);
    logic [23:0] c;
    if (iter == max_iter) c = 24'h000000;
    else                  c = {iter, 8'hFF - iter, 8'h80};
    return c;
  endfunction

  // Full-width signed product, rescaled back to Q8.24.
  function automatic fx_t fx_mul(input fx_t a, input fx_t b);
    logic signed [2*FX_WIDTH-1:0] ae;
    logic signed [2*FX_WIDTH-1:0] be;
    logic signed [2*FX_WIDTH-1:0] p;
    ae = a;
    be = b;
    p  = ae * be;
    return fx_t'(p >>> FRAC_BITS);
  endfunction

endpackage

// File: rtl/mandelbrot_pixel_engine_pixel_stride_counter.sv
// Strided raster walker: holds this engine's current (x, y) and applies stride/line/frame wrap.
module pixel_stride_counter #(
  parameter int DATA_WIDTH    = 32,
  parameter int SCREEN_WIDTH  = 1280,
  parameter int SCREEN_HEIGHT = 720,
  parameter int NUM_ENGINES   = 6,
  parameter int ENGINE_ID     = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  advance,
  output logic [DATA_WIDTH-1:0] x,
  output logic [DATA_WIDTH-1:0] y
);

  localparam logic [DATA_WIDTH-1:0] STRIDE = DATA_WIDTH'(NUM_ENGINES);
  localparam logic [DATA_WIDTH-1:0] SW     = DATA_WIDTH'(SCREEN_WIDTH);
  localparam logic [DATA_WIDTH-1:0] LAST_Y = DATA_WIDTH'(SCREEN_HEIGHT - 1);
  localparam logic [DATA_WIDTH-1:0] X0     = DATA_WIDTH'(ENGINE_ID);

  logic [DATA_WIDTH-1:0] xn;

  assign xn = x + STRIDE;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x <= X0;
      y <= '0;
    end else if (advance) begin
      if (xn >= SW) begin
        x <= xn - SW;
        y <= (y == LAST_Y) ? '0 : y + 1'b1;
      end else begin
        x <= xn;
      end
    end
  end

endmodule

// File: rtl/mandelbrot_pixel_engine.sv
// Escape-time Mandelbrot engine for a strided pixel subset; holds each result until taken.
// Optional build macro ENGINE_PERF_EN adds iteration/pixel performance counters.
module mandelbrot_pixel_engine
  import mandelbrot_pkg::*;
#(
  parameter int                    DATA_WIDTH    = 32,
  parameter int                    RBG_SIZE      = 24,
  parameter int                    SCREEN_WIDTH  = 1280,
  parameter int                    SCREEN_HEIGHT = 720,
  parameter int                    NUM_ENGINES   = 6,
  parameter int                    ENGINE_ID     = 0,
  parameter int                    MAX_ITER      = 255,
  parameter logic [DATA_WIDTH-1:0] X_MIN         = 32'hFE000000,
  parameter logic [DATA_WIDTH-1:0] Y_MIN         = 32'hFEE00000,
  parameter logic [DATA_WIDTH-1:0] STEP          = 32'd39322
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  taken_i,
  output logic [RBG_SIZE-1:0]   colour_o,
  output logic [DATA_WIDTH-1:0] xpixel_o,
  output logic [DATA_WIDTH-1:0] ypixel_o,
`ifdef ENGINE_PERF_EN
  output logic [31:0]           iter_total_o,
  output logic [31:0]           pixels_done_o,
`endif
  output logic                  busy_o
);

  localparam logic [7:0] MAX_IT = 8'(MAX_ITER);

  state_t state, state_next;

  logic [DATA_WIDTH-1:0] x, y;
  logic                  advance;
  logic                  finish;

  fx_t cr, ci, zr, zi;
  fx_t zr2, zi2, zri, mag;
  logic [7:0] iter;

  pixel_stride_counter #(
    .DATA_WIDTH   (DATA_WIDTH),
    .SCREEN_WIDTH (SCREEN_WIDTH),
    .SCREEN_HEIGHT(SCREEN_HEIGHT),
    .NUM_ENGINES  (NUM_ENGINES),
    .ENGINE_ID    (ENGINE_ID)
  ) u_stride (
    .clk    (clk),
    .reset  (reset),
    .advance(advance),
    .x      (x),
    .y      (y)
  );

  assign zr2    = fx_mul(zr, zr);
  assign zi2    = fx_mul(zi, zi);
  assign zri    = fx_mul(zr, zi);
  assign mag    = zr2 + zi2;
  assign finish = (mag > ESCAPE_R2) || (iter == MAX_IT);

  always_comb begin
    state_next = state;
    advance    = 1'b0;
    case (state)
      INIT: state_next = ITER;
      ITER: if (finish) state_next = DONE;
      DONE: if (taken_i) begin
        state_next = INIT;
        advance    = 1'b1;
      end
      default: state_next = INIT;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= INIT;
    else       state <= state_next;
  end

  // Escape is tested on the current z before updating, so |z| <= 2 whenever z is rewritten.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cr       <= '0;
      ci       <= '0;
      zr       <= '0;
      zi       <= '0;
      iter     <= '0;
      colour_o <= '0;
      xpixel_o <= '1;
      ypixel_o <= '1;
      busy_o   <= 1'b1;
    end else begin
      busy_o <= (state_next != DONE);
      case (state)
        INIT: begin
          cr   <= fx_t'(X_MIN + x * STEP);
          ci   <= fx_t'(Y_MIN + y * STEP);
          zr   <= '0;
          zi   <= '0;
          iter <= '0;
        end
        ITER: begin
          if (finish) begin
            colour_o <= RBG_SIZE'(colour_map(iter, MAX_IT));
            xpixel_o <= x;
            ypixel_o <= y;
          end else begin
            zr   <= zr2 - zi2 + cr;
            zi   <= (zri <<< 1) + ci;
            iter <= iter + 8'd1;
          end
        end
        DONE: begin
          if (taken_i) begin
            xpixel_o <= '1;
            ypixel_o <= '1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef ENGINE_PERF_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      iter_total_o  <= '0;
      pixels_done_o <= '0;
    end else begin
      if (state == ITER && finish) iter_total_o  <= iter_total_o + 32'(iter);
      if (advance)                 pixels_done_o <= pixels_done_o + 32'd1;
    end
  end
`endif

endmodule
